// File: rtl/fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_wb_arbiter
// Description : Round-robin writeback arbiter feeding the single write port
//               of the FP register file. It accepts one producer per cycle
//               over valid/ready and registers the write one cycle later.
//               It also emits a retire pulse and a saturating write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_wb_arbiter #(
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*5-1:0]      src_waddr,
  input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
  input  logic                      hold,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      retire_valid,
  output logic [4:0]                retire_addr,
  output logic [CNT_W-1:0]          wr_count
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_we;
  logic [4:0]        r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_wr_count;

  logic              w_found;
  logic              w_xfer;
  logic [PTR_W-1:0]  w_gidx;

  // Rotating priority scan: the first valid producer at or after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_found && src_valid[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
        w_found = 1'b1;
        w_gidx  = PTR_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  // A grant is only issued outside reset and while not frozen by hold; the
  // reset gating guarantees a transfer cannot slip in during reset.
  always_comb begin
    w_xfer    = w_found && !hold && rst_n;
    src_ready = '0;
    if (w_xfer) begin
      src_ready = NUM_SRC'(1) << w_gidx;
    end
  end

  // Registered write stage, pointer advance and saturating write counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_rr_ptr   <= '0;
      r_wr_count <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_waddr  <= src_waddr[5*w_gidx +: 5];
        r_wdata  <= src_wdata[DATA_W*w_gidx +: DATA_W];
        r_rr_ptr <= (w_gidx == c_last_idx) ? '0 : w_gidx + 1'b1;
        if (r_wr_count != c_cnt_max) begin
          r_wr_count <= r_wr_count + 1'b1;
        end
      end
    end
  end

  assign rf_we        = r_we;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign retire_valid = r_we;
  assign retire_addr  = r_waddr;
  assign wr_count     = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_wb_arbiter
// Description : Self-checking bench for fp_wb_arbiter. A narrow counter is
//               used so that saturation is reached by real traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_wb_arbiter;

  localparam int DW   = 16;
  localparam int NS   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NS-1:0]    src_valid = '0;
  logic [NS-1:0]    src_ready;
  logic [NS*5-1:0]  src_waddr = '0;
  logic [NS*DW-1:0] src_wdata = '0;
  logic             hold = 1'b0;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic             retire_valid;
  logic [4:0]       retire_addr;
  logic [CW-1:0]    wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the register-file port should show this cycle.
  int            m_ptr;
  logic          m_we;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_cnt;

  fp_wb_arbiter #(.DATA_W(DW), .NUM_SRC(NS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_waddr(src_waddr), .src_wdata(src_wdata), .hold(hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_valid(retire_valid), .retire_addr(retire_addr), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Round-robin rule: first valid at ptr, ptr+1, ... mod NS; -1 if none.
  function automatic int ref_grant(input logic [NS-1:0] v, input logic h, input int ptr);
    if (h) return -1;
    for (int k = 0; k < NS; k++) begin
      if (v[(ptr + k) % NS]) return (ptr + k) % NS;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] onehot(input int g);
    logic [NS-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_src(input int i, input logic [4:0] a, input logic [DW-1:0] d);
    src_waddr[5*i +: 5]   = a;
    src_wdata[DW*i +: DW] = d;
  endtask

  // Advance one clock and apply the transfer (if any) to the reference.
  task automatic clock_model(input int g);
    @(posedge clk);
    m_we = (g >= 0);
    if (g >= 0) begin
      m_waddr = src_waddr[5*g +: 5];
      m_wdata = src_wdata[DW*g +: DW];
      m_ptr   = (g + 1) % NS;
      if (m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src_valid = '0; hold = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_valid = 3'b111; hold = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (src_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", src_ready); end
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0 || wr_count !== '0 || retire_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got we=%b a=%0d d=%h cnt=%0d exp all zero", rf_we, rf_waddr, rf_wdata, wr_count);
    end
    src_valid = '0;
    @(posedge clk); #1;
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (src_ready !== 3'b000 || rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_idle got ready=%b we=%b exp 000/0", src_ready, rf_we); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_reset();
    set_src(1, 5'd5, 16'h3C00);
    src_valid = 3'b010;
    @(negedge clk);
    n_checks++;
    if (src_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready got=%b exp=010", src_ready); end
    clock_model(ref_grant(src_valid, hold, m_ptr));
    src_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 16'h3C00 || retire_valid !== 1'b1 || retire_addr !== 5'd5) begin
      n_fail++; $display("FAIL single_write got we=%b a=%0d d=%h exp 1/5/3c00", rf_we, rf_waddr, rf_wdata);
    end
    clock_model(-1);
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 16'h3C00 || wr_count !== 4'd1) begin
      n_fail++; $display("FAIL single_idle got we=%b a=%0d d=%h cnt=%0d exp 0/5/3c00/1", rf_we, rf_waddr, rf_wdata, wr_count);
    end
  endtask

  task automatic test_all_valid();
    do_reset();
    for (int i = 0; i < NS; i++) set_src(i, 5'(10 + i), 16'(16'hA000 + i));
    src_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (src_ready !== onehot(c % NS) || rf_we !== (c > 0)) begin
        n_fail++; $display("FAIL all_valid_c%0d got ready=%b we=%b exp ready=%b", c, src_ready, rf_we, onehot(c % NS));
      end
      if (c > 0) begin
        n_checks++;
        if (rf_waddr !== 5'(10 + (c - 1) % NS)) begin n_fail++; $display("FAIL all_valid_addr_c%0d got=%0d exp=%0d", c, rf_waddr, 10 + (c - 1) % NS); end
      end
      clock_model(c % NS);
    end
    src_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b1 || wr_count !== 4'd6) begin n_fail++; $display("FAIL all_valid_count got we=%b cnt=%0d exp 1/6", rf_we, wr_count); end
    clock_model(-1);
  endtask

  task automatic test_pair_wrap();
    do_reset();
    set_src(0, 5'd1, 16'h1111); set_src(1, 5'd2, 16'h2222); set_src(2, 5'd3, 16'h3333);
    src_valid = 3'b001;
    clock_model(0);
    src_valid = 3'b101;
    @(negedge clk);
    n_checks++;
    if (src_ready !== 3'b100) begin n_fail++; $display("FAIL pair_first got=%b exp=100", src_ready); end
    clock_model(2);
    src_valid = 3'b001;
    @(negedge clk);
    n_checks++;
    if (src_ready !== 3'b001 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL pair_wrap got ready=%b a=%0d exp 001/3", src_ready, rf_waddr); end
    clock_model(0);
    src_valid = 3'b011;
    @(negedge clk);
    n_checks++;
    if (src_ready !== 3'b010) begin n_fail++; $display("FAIL pair_ptr got=%b exp=010", src_ready); end
    src_valid = '0;
    clock_model(-1);
  endtask

  task automatic test_hold();
    do_reset();
    src_valid = 3'b001;
    clock_model(0);
    hold = 1'b1; src_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (src_ready !== 3'b000 || rf_we !== (c == 0)) begin
        n_fail++; $display("FAIL hold_c%0d got ready=%b we=%b exp 000/%0d", c, src_ready, rf_we, (c == 0));
      end
      clock_model(-1);
    end
    hold = 1'b0;
    @(negedge clk);
    n_checks++;
    if (src_ready !== 3'b010 || wr_count !== 4'd1) begin n_fail++; $display("FAIL hold_resume got ready=%b cnt=%0d exp 010/1", src_ready, wr_count); end
    src_valid = '0;
    clock_model(-1);
  endtask

  task automatic test_saturation();
    do_reset();
    src_valid = 3'b111;
    for (int c = 0; c < CMAX + 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (wr_count !== CW'((c < CMAX) ? c : CMAX)) begin
        n_fail++; $display("FAIL sat_c%0d got=%0d exp=%0d", c, wr_count, (c < CMAX) ? c : CMAX);
      end
      clock_model(ref_grant(src_valid, hold, m_ptr));
    end
    src_valid = '0;
    @(negedge clk);
    n_checks++;
    if (wr_count !== 4'hF) begin n_fail++; $display("FAIL sat_final got=%0d exp=15", wr_count); end
    clock_model(-1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_src(0, 5'd7, 16'h7777); set_src(1, 5'd8, 16'h8888);
    src_valid = 3'b001;
    clock_model(0);
    rst_n = 1'b0; src_valid = 3'b010;
    @(negedge clk);
    n_checks++;
    if (src_ready !== 3'b000 || rf_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_during got ready=%b we=%b exp 000/1", src_ready, rf_we); end
    @(posedge clk); #1;
    rst_n = 1'b1; src_valid = '0;
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || wr_count !== 4'd0) begin
      n_fail++; $display("FAIL rstmid_after got we=%b a=%0d cnt=%0d exp 0/0/0", rf_we, rf_waddr, wr_count);
    end
    clock_model(-1);
  endtask

  task automatic test_random();
    int g;
    int wait_cnt [NS];
    do_reset();
    for (int i = 0; i < NS; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      g = ref_grant(src_valid, hold, m_ptr);
      n_checks++;
      if (src_ready !== onehot(g) || rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata ||
          retire_valid !== m_we || retire_addr !== m_waddr || wr_count !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_c%0d got ready=%b we=%b a=%0d d=%h cnt=%0d exp ready=%b we=%b a=%0d d=%h cnt=%0d",
                 c, src_ready, rf_we, rf_waddr, rf_wdata, wr_count, onehot(g), m_we, m_waddr, m_wdata, m_cnt);
      end
      for (int i = 0; i < NS; i++) begin
        if (src_valid[i] && !hold && g != i) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] >= NS) begin
          n_checks++; n_fail++; $display("FAIL rand_starve src=%0d got_wait=%0d exp_below=%0d", i, wait_cnt[i], NS);
        end
      end
      clock_model(g);
      if (g >= 0) src_valid[g] = 1'b0;
      for (int i = 0; i < NS; i++) begin
        if (!src_valid[i] && ($urandom_range(0, 3) != 0)) begin
          set_src(i, 5'($urandom_range(0, 31)), 16'($urandom));
          src_valid[i] = 1'b1;
        end
      end
      hold = ($urandom_range(0, 7) == 0);
    end
    src_valid = '0; hold = 1'b0;
    clock_model(-1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_pair_wrap();
    test_hold();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
